// File: rtl/wallace_mult_pipelined.sv
// rtl/wallace_mult_pipelined.sv - pipelined Baugh-Wooley/Wallace multiplier with tag sideband and backpressure
module wallace_mult_pipelined #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);
    // Operands are widened by one bit so both modes share one signed (WIDTH+1)-bit array.
    localparam int N      = WIDTH + 1;
    localparam int PW     = 2 * WIDTH;
    localparam int R      = N + 1;
    localparam int LAYERS = 10;
    localparam int MID    = (STAGES > 2) ? STAGES - 2 : 1;

    typedef struct packed {
        logic [PW-1:0] s;
        logic [PW-1:0] c;
    } csa_t;

    logic               adv;
    logic               v1;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b1;
    logic               sgn1;
    logic [TAG_W-1:0]   t1;
    csa_t               red;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Columns at or above 2*WIDTH are dropped: the product is exact modulo 2^(2*WIDTH).
    function automatic csa_t reduce_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sgn);
        logic [N-1:0]          ax;
        logic [N-1:0]          bx;
        logic [R-1:0][PW-1:0]  cur;
        logic [R-1:0][PW-1:0]  nxt;
        int                    cnt;
        int                    ncnt;
        csa_t                  res;
        ax  = {sgn & a[WIDTH-1], a};
        bx  = {sgn & b[WIDTH-1], b};
        cur = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i + j < PW)
                    cur[i][i+j] = (ax[i] & bx[j]) ^ ((i == N - 1) != (j == N - 1));
        cur[N][N] = 1'b1;
        cnt = R;
        for (int l = 0; l < LAYERS; l++) begin
            nxt  = '0;
            ncnt = 0;
            for (int g = 0; g < R; g += 3) begin
                if (g + 2 < cnt) begin
                    nxt[ncnt]   = cur[g] ^ cur[g+1] ^ cur[g+2];
                    nxt[ncnt+1] = ((cur[g] & cur[g+1]) | (cur[g] & cur[g+2]) |
                                   (cur[g+1] & cur[g+2])) << 1;
                    ncnt += 2;
                end else begin
                    if (g < cnt) begin
                        nxt[ncnt] = cur[g];
                        ncnt++;
                    end
                    if (g + 1 < cnt) begin
                        nxt[ncnt] = cur[g+1];
                        ncnt++;
                    end
                end
            end
            cur = nxt;
            cnt = ncnt;
        end
        res.s = cur[0];
        res.c = cur[1];
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            sgn1 <= 1'b0;
            t1   <= '0;
        end else if (adv) begin
            v1   <= in_valid;
            a1   <= in_a;
            b1   <= in_b;
            sgn1 <= in_signed;
            t1   <= in_tag;
        end
    end

    always_comb begin
        red = reduce_pp(a1, b1, sgn1);
    end

    generate
        if (STAGES == 2) begin : g_short
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_p     <= '0;
                    out_tag   <= '0;
                end else if (adv) begin
                    out_valid <= v1;
                    out_p     <= red.s + red.c;
                    out_tag   <= t1;
                end
            end
        end else begin : g_long
            // Carry-save rows ride the middle stages; the final add sits ahead of the output register.
            logic [MID-1:0]            mv;
            logic [MID-1:0][PW-1:0]    ms;
            logic [MID-1:0][PW-1:0]    mc;
            logic [MID-1:0][TAG_W-1:0] mt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mv        <= '0;
                    ms        <= '0;
                    mc        <= '0;
                    mt        <= '0;
                    out_valid <= 1'b0;
                    out_p     <= '0;
                    out_tag   <= '0;
                end else if (adv) begin
                    mv[0] <= v1;
                    ms[0] <= red.s;
                    mc[0] <= red.c;
                    mt[0] <= t1;
                    for (int k = 1; k < MID; k++) begin
                        mv[k] <= mv[k-1];
                        ms[k] <= ms[k-1];
                        mc[k] <= mc[k-1];
                        mt[k] <= mt[k-1];
                    end
                    out_valid <= mv[MID-1];
                    out_p     <= ms[MID-1] + mc[MID-1];
                    out_tag   <= mt[MID-1];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_wallace_mult_pipelined.sv
// tb/tb_wallace_mult_pipelined.sv - self-checking bench for wallace_mult_pipelined
module tb_wallace_mult_pipelined;
    localparam int LAT = 4;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [3:0]  t;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [3:0] t;
    } op_t;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_p;
    logic [3:0]  out_tag;

    logic        v16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        s16 = 1'b0;
    logic [3:0]  t16 = '0;
    logic        ir2, ir8, ov2, ov8;
    logic [31:0] p2, p8;
    logic [3:0]  ot2, ot8;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    res_t q[$];
    op_t  ops[$];

    always #5 clk = ~clk;

    wallace_mult_pipelined #(.WIDTH(8), .STAGES(LAT), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag));

    wallace_mult_pipelined #(.WIDTH(16), .STAGES(2), .TAG_W(4)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir2),
        .in_a(a16), .in_b(b16), .in_signed(s16), .in_tag(t16),
        .out_valid(ov2), .out_ready(1'b1), .out_p(p2), .out_tag(ot2));

    wallace_mult_pipelined #(.WIDTH(16), .STAGES(8), .TAG_W(4)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir8),
        .in_a(a16), .in_b(b16), .in_signed(s16), .in_tag(t16),
        .out_valid(ov8), .out_ready(1'b1), .out_p(p8), .out_tag(ot8));

    function automatic res_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic s, input logic [3:0] t);
        int   ai, bi, p;
        res_t r;
        ai  = s ? int'($signed(a)) : int'(a);
        bi  = s ? int'($signed(b)) : int'(b);
        p   = ai * bi;
        r.p = p[15:0];
        r.t = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: whatever is accepted must come back once, in order, with the modelled product.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got p=%h tag=%h exp none", out_p, out_tag);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    n_out++;
                    if (out_p !== e.p || out_tag !== e.t) begin
                        errors++;
                        $display("FAIL stream_result got p=%h tag=%h exp p=%h tag=%h",
                                 out_p, out_tag, e.p, e.t);
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(model8(in_a, in_b, in_signed, in_tag));
        end
    end

    task automatic present(input op_t o);
        in_a      = o.a;
        in_b      = o.b;
        in_signed = o.s;
        in_tag    = o.t;
        in_valid  = 1'b1;
    endtask

    task automatic run_one(input vec_t v, input int idx);
        int n;
        op_t o;
        o.a = v.a; o.b = v.b; o.s = v.s; o.t = v.t;
        present(o);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(LAT));
        chk($sformatf("vec%0d_p", idx), 64'(out_p), 64'(v.p));
        chk($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(v.t));
        step();
    endtask

    task automatic run_ops(input bit throttle);
        int  guard;
        bit  acc;
        op_t o;
        guard = 0;
        while ((ops.size() > 0 || in_valid || q.size() > 0) && guard < 20000) begin
            if (!in_valid && ops.size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
                o = ops.pop_front();
                present(o);
            end
            out_ready = !throttle || ($urandom_range(3) != 0);
            #1;
            acc = in_valid && in_ready;
            step();
            guard++;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        chk("stream_drain_timeout", 64'(guard < 20000), 64'(1));
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint ai, bi, pp;
        logic [31:0] e;
        ai = s ? longint'($signed(a)) : longint'(a);
        bi = s ? longint'($signed(b)) : longint'(b);
        pp = ai * bi;
        e  = pp[31:0];
        a16 = a; b16 = b; s16 = s; t16 = t16 + 4'd1; v16 = 1'b1;
        step();
        v16 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("w16_s2_valid", 64'(ov2), 64'(k == 2));
            chk("w16_s8_valid", 64'(ov8), 64'(k == 8));
            if (k == 2) chk("w16_s2_p", 64'(p2), 64'(e));
            if (k == 8) begin
                chk("w16_s8_p", 64'(p8), 64'(e));
                chk("w16_s8_tag", 64'(ot8), 64'(t16));
            end
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[12];
        op_t   o;
        logic [7:0]  cv[5];
        logic [15:0] cw[5];
        logic [15:0] held_p;
        logic [3:0]  held_t;
        int    sent, n0, stall_left, stale;
        bit    stalled, acc, was_stall;

        vt[0]  = '{8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01};
        vt[1]  = '{8'h80, 8'h80, 1'b1, 4'h1, 16'h4000};
        vt[2]  = '{8'hFF, 8'h7F, 1'b1, 4'h2, 16'hFF81};
        vt[3]  = '{8'h80, 8'h80, 1'b0, 4'h4, 16'h4000};
        vt[4]  = '{8'h7F, 8'h7F, 1'b1, 4'h5, 16'h3F01};
        vt[5]  = '{8'h00, 8'hFF, 1'b0, 4'h6, 16'h0000};
        vt[6]  = '{8'h80, 8'h7F, 1'b1, 4'h7, 16'hC080};
        vt[7]  = '{8'hFF, 8'hFF, 1'b1, 4'h8, 16'h0001};
        vt[8]  = '{8'hFF, 8'h7F, 1'b0, 4'h9, 16'h7E81};
        vt[9]  = '{8'h80, 8'h01, 1'b1, 4'hA, 16'hFF80};
        vt[10] = '{8'h12, 8'h34, 1'b0, 4'hB, 16'h03A8};
        vt[11] = '{8'hF0, 8'h0F, 1'b1, 4'hC, 16'hFF10};

        repeat (2) step();
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_p", 64'(out_p), 64'(0));
        chk("reset_out_tag", 64'(out_tag), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_one(vt[i], i);

        // Two signed ops on consecutive edges come back on consecutive cycles.
        o = '{8'h80, 8'h80, 1'b1, 4'hD};
        present(o);
        step();
        o = '{8'hFF, 8'h7F, 1'b1, 4'hE};
        present(o);
        step();
        in_valid = 1'b0;
        sent = 2;
        while (!out_valid && sent < 12) begin
            step();
            sent++;
        end
        chk("b2b_first_p", 64'(out_p), 64'(16'h4000));
        step();
        chk("b2b_second_valid", 64'(out_valid), 64'(1));
        chk("b2b_second_p", 64'(out_p), 64'(16'hFF81));
        step();

        // Ten mixed ops with a three-cycle downstream stall once results are flowing.
        n0 = n_out; sent = 0; stall_left = 0; stalled = 0;
        o = '{8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom)};
        present(o);
        for (int c = 0; c < 80 && (n_out - n0) < 10; c++) begin
            if (!stalled && sent >= 6 && out_valid) begin
                stalled = 1; stall_left = 3; held_p = out_p; held_t = out_tag;
            end
            out_ready = (stall_left == 0);
            #1;
            was_stall = (stall_left > 0);
            if (was_stall) chk("stall_in_ready", 64'(in_ready), 64'(0));
            acc = in_valid && in_ready;
            step();
            if (was_stall) begin
                stall_left--;
                chk("stall_hold_p", 64'(out_p), 64'(held_p));
                chk("stall_hold_tag", 64'(out_tag), 64'(held_t));
                chk("stall_hold_valid", 64'(out_valid), 64'(1));
            end
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    o = '{8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom)};
                    present(o);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b1;
        chk("stall_stream_count", 64'(n_out - n0), 64'(10));
        chk("stall_happened", 64'(stalled), 64'(1));
        chk("stall_queue_empty", 64'(q.size()), 64'(0));

        // Corner operands in both modes, then a throttled random soak.
        cv[0] = 8'h00; cv[1] = 8'h01; cv[2] = 8'h7F; cv[3] = 8'h80; cv[4] = 8'hFF;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    ops.push_back('{cv[i], cv[j], 1'(m), 4'(i * 5 + j)});
        n0 = n_out;
        run_ops(1'b0);
        chk("corner_count", 64'(n_out - n0), 64'(50));
        for (int i = 0; i < 1500; i++)
            ops.push_back('{8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom)});
        n0 = n_out;
        run_ops(1'b1);
        chk("soak_count", 64'(n_out - n0), 64'(1500));

        // Asynchronous reset with results in flight and one parked at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = '{8'(8'h11 + i), 8'h23, 1'b0, 4'(i + 1)};
            present(o);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'(0));
        chk("async_reset_p", 64'(out_p), 64'(0));
        chk("async_reset_tag", 64'(out_tag), 64'(0));
        chk("async_reset_in_ready", 64'(in_ready), 64'(1));
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'(1));
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) stale++;
            step();
        end
        chk("stale_results", 64'(stale), 64'(0));

        // Wider operands at both depth extremes.
        cw[0] = 16'h0000; cw[1] = 16'h0001; cw[2] = 16'h7FFF; cw[3] = 16'h8000; cw[4] = 16'hFFFF;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    run16(cw[i], cw[j], 1'(m));
        for (int i = 0; i < 20; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        chk("w16_in_ready", 64'({ir2, ir8}), 64'(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
